// File: rtl/rns_pkg.sv
// Shared constants, state encoding and constant-multiply helpers for the
// {3,5,7} residue-to-binary converter.
package rns_pkg;

  localparam int RES_W = 3;
  localparam int BIN_W = 7;

  localparam logic [RES_W-1:0] M3      = 3'd3;
  localparam logic [RES_W-1:0] M5      = 3'd5;
  localparam logic [RES_W-1:0] M7      = 3'd7;
  localparam logic [RES_W-1:0] INV3_M5 = 3'd2;
  localparam logic [RES_W-1:0] INV5_M7 = 3'd3;
  localparam logic [BIN_W-1:0] M35     = 7'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC_A2 = 3'd1,
    S_CALC_A3 = 3'd2,
    S_SUM     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  // Constant product built from shifted copies of x, one per set bit of k.
  function automatic logic [BIN_W-1:0] shift_add(input logic [BIN_W-1:0] x,
                                                 input logic [BIN_W-1:0] k);
    logic [BIN_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < BIN_W; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

  // x*k mod m. For digit-range x and the small constants used here the
  // product stays below 2m, so a single compare-subtract suffices.
  function automatic logic [RES_W-1:0] mul_mod(input logic [RES_W-1:0] x,
                                               input logic [RES_W-1:0] k,
                                               input logic [RES_W-1:0] m);
    logic [BIN_W-1:0] p;
    p = shift_add(BIN_W'(x), BIN_W'(k));
    if (p >= BIN_W'(m)) p = p - BIN_W'(m);
    return RES_W'(p);
  endfunction

endpackage

// File: rtl/mod_sub_reduce.sv
// (a - b) mod m for operands already below m: subtract, add m back on borrow.
module mod_sub_reduce
  import rns_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  input  logic [RES_W-1:0] m,
  output logic [RES_W-1:0] y
);

  logic [RES_W:0] diff;

  assign diff = {1'b0, a} - {1'b0, b};
  assign y    = diff[RES_W] ? RES_W'(diff[RES_W-1:0] + m) : diff[RES_W-1:0];

endmodule

// File: rtl/rns_357_to_binary.sv
// Sequential mixed-radix reverse converter for residues (r3, r5, r7) -> X in 0..104.
// state     | meaning
// S_IDLE    | in_ready high, waiting for a residue triple
// S_CALC_A2 | registering digit a2
// S_CALC_A3 | registering digit a3
// S_SUM     | registering X / err, raising out_valid
// S_HOLD    | result held until out_ready
module rns_357_to_binary
  import rns_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_r3,
  input  logic [RES_W-1:0] in_r5,
  input  logic [RES_W-1:0] in_r7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_data,
  output logic             out_err
);

  state_t           state;
  logic [1:0]       a1_q;
  logic [RES_W-1:0] r5_q;
  logic [RES_W-1:0] r7_q;
  logic             err_q;
  logic [RES_W-1:0] a2_q;
  logic [RES_W-1:0] a3_q;

  logic [RES_W-1:0] d5;
  logic [RES_W-1:0] a2_next;
  logic [RES_W-1:0] t7;
  logic [RES_W-1:0] p7;
  logic [RES_W-1:0] a3_next;
  logic [BIN_W-1:0] sum;
  logic             in_err;

  assign in_err = (in_r3 >= M3) | (in_r5 >= M5) | (in_r7 >= M7);

  mod_sub_reduce u_sub_a2 (
    .a (r5_q),
    .b ({1'b0, a1_q}),
    .m (M5),
    .y (d5)
  );

  assign a2_next = mul_mod(d5, INV3_M5, M5);

  // a3 = (r7 - a1 - 3*a2) mod 7, as two chained modular subtractions.
  mod_sub_reduce u_sub_a3_r (
    .a (r7_q),
    .b ({1'b0, a1_q}),
    .m (M7),
    .y (t7)
  );

  assign p7 = mul_mod(a2_q, INV5_M7, M7);

  mod_sub_reduce u_sub_a3_p (
    .a (t7),
    .b (p7),
    .m (M7),
    .y (a3_next)
  );

  assign sum = BIN_W'(a1_q)
             + shift_add(BIN_W'(a2_q), BIN_W'(M3))
             + shift_add(BIN_W'(a3_q), M35);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      a1_q      <= '0;
      r5_q      <= '0;
      r7_q      <= '0;
      err_q     <= 1'b0;
      a2_q      <= '0;
      a3_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a1_q     <= in_r3[1:0];
            r5_q     <= in_r5;
            r7_q     <= in_r7;
            err_q    <= in_err;
            in_ready <= 1'b0;
            state    <= S_CALC_A2;
          end
        end
        S_CALC_A2: begin
          a2_q  <= a2_next;
          state <= S_CALC_A3;
        end
        S_CALC_A3: begin
          a3_q  <= a3_next;
          state <= S_SUM;
        end
        S_SUM: begin
          out_data  <= err_q ? '0 : sum;
          out_err   <= err_q;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns_357_to_binary.sv
// Self-checking bench for rns_357_to_binary: directed table, exhaustive sweep,
// random triples against a CRT search model, stall and mid-operation reset.
module tb_rns_357_to_binary;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_r3;
  logic [2:0] in_r5;
  logic [2:0] in_r7;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       out_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rns_357_to_binary dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r3     (in_r3),
    .in_r5     (in_r5),
    .in_r7     (in_r7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  typedef struct {
    logic [2:0] r3;
    logic [2:0] r5;
    logic [2:0] r7;
    logic [6:0] x;
    logic       err;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: X is the unique value in [0,105) with the given residues.
  task automatic ref_model(input int r3, input int r5, input int r7,
                           output int x, output bit err);
    err = (r3 > 2) || (r5 > 4) || (r7 > 6);
    x = 0;
    if (!err) begin
      for (int k = 0; k < 105; k++) begin
        if ((k % 3 == r3) && (k % 5 == r5) && (k % 7 == r7)) x = k;
      end
    end
  endtask

  task automatic wait_out_valid(input string name);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, " out_valid timeout"}, out_valid, 1);
  endtask

  task automatic run_txn(input logic [2:0] r3, input logic [2:0] r5, input logic [2:0] r7,
                         input logic [6:0] exp_x, input logic exp_err, input string name);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, " in_ready"}, in_ready, 1);
    in_r3    = r3;
    in_r5    = r5;
    in_r7    = r7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, " busy"}, in_ready, 0);
    @(negedge clk);
    check({name, " valid E1"}, out_valid, 0);
    @(negedge clk);
    check({name, " valid E2"}, out_valid, 0);
    @(negedge clk);
    check({name, " valid E3"}, out_valid, 1);
    check({name, " data"}, out_data, exp_x);
    check({name, " err"}, out_err, exp_err);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid drop"}, out_valid, 0);
    check({name, " ready back"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  x_m;
    bit  e_m;
    logic [2:0] rr3, rr5, rr7;

    tbl[0] = '{r3: 3'd1, r5: 3'd2, r7: 3'd3, x: 7'd52,  err: 1'b0};
    tbl[1] = '{r3: 3'd2, r5: 3'd4, r7: 3'd6, x: 7'd104, err: 1'b0};
    tbl[2] = '{r3: 3'd0, r5: 3'd0, r7: 3'd0, x: 7'd0,   err: 1'b0};
    tbl[3] = '{r3: 3'd0, r5: 3'd5, r7: 3'd0, x: 7'd0,   err: 1'b1};
    tbl[4] = '{r3: 3'd3, r5: 3'd0, r7: 3'd7, x: 7'd0,   err: 1'b1};
    tbl[5] = '{r3: 3'd2, r5: 3'd3, r7: 3'd1, x: 7'd8,   err: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_r3     = '0;
    in_r5     = '0;
    in_r7     = '0;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_err", out_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].r3, tbl[i].r5, tbl[i].r7, tbl[i].x, tbl[i].err, $sformatf("tbl%0d", i));
    end

    for (int x = 0; x < 105; x++) begin
      run_txn(3'(x % 3), 3'(x % 5), 3'(x % 7), 7'(x), 1'b0, $sformatf("sweep%0d", x));
    end

    for (int i = 0; i < 40; i++) begin
      rr3 = 3'($urandom_range(0, 7));
      rr5 = 3'($urandom_range(0, 7));
      rr7 = 3'($urandom_range(0, 7));
      ref_model(int'(rr3), int'(rr5), int'(rr7), x_m, e_m);
      run_txn(rr3, rr5, rr7, 7'(x_m), e_m, $sformatf("rand%0d", i));
    end

    // Consumer stall with a competing triple on the input.
    in_r3 = 3'd1; in_r5 = 3'd2; in_r7 = 3'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid("stall");
    in_r3 = 3'd2; in_r5 = 3'd4; in_r7 = 3'd6;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("stall data", out_data, 52);
      check("stall valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall release valid", out_valid, 0);
    check("stall release ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall next accepted", in_ready, 0);
    wait_out_valid("stall next");
    check("stall next data", out_data, 104);
    check("stall next err", out_err, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted while the FSM is in CALC_A3.
    in_r3 = 3'd1; in_r5 = 3'd2; in_r7 = 3'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_data", out_data, 0);
    check("midrst out_err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(3'd2, 3'd3, 3'd1, 7'd8, 1'b0, "post reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rns_357_to_binary.md
# rns_357_to_binary

Reverse (residue-to-binary) converter for the fixed moduli set {3, 5, 7}, dynamic range M = 105. It sits directly downstream of the per-modulus remainder stages. It accepts one residue triple (r3, r5, r7) per transaction over a valid/ready handshake and reconstructs the 7-bit binary value X ∈ [0,104] by sequential mixed-radix conversion. It then holds X until the consumer takes it.

## Interface
- Parameters: none. The moduli set is fixed and its constants live in the shared package.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  residue triple on in_r3/in_r5/in_r7 is valid
- in_ready  out  1  block can accept a triple (high only in IDLE)
- in_r3  in  3  residue mod 3; legal values 0..2
- in_r5  in  3  residue mod 5; legal values 0..4
- in_r7  in  3  residue mod 7; legal values 0..6
- out_valid  out  1  out_data/out_err are valid
- out_ready  in  1  consumer takes the result
- out_data  out  7  reconstructed X, 0..104; forced to 0 when out_err=1
- out_err  out  1  one or more input residues were out of range

## Operation
- Mixed-radix digits:
  - a1 = r3
  - a2 = ((r5 − a1) · 2) mod 5, where 2 = 3⁻¹ mod 5
  - a3 = (r7 − a1 − 3·a2) mod 7, which is the simplified form of (((r7−a1)·5 − a2)·3) mod 7
- Result: X = a1 + 3·a2 + 15·a3.
- All modular subtractions use (a − b) mod m with a, b < m: subtract, then add m on borrow. Products use constant shift-add followed by compare-subtract reduction. No dividers.
- Intermediate widths: a1 is 2 bits, a2 is 3 bits, a3 is 3 bits. Sum is 7 bits with no overflow, since the maximum is 2+12+90 = 104.
- Range check at accept: err = (r3>2) | (r5>4) | (r7>6), registered with the residues. If err=1, digit computation still runs, but out_data is forced to 0 and out_err=1.
- FSM states: IDLE → CALC_A2 → CALC_A3 → SUM → HOLD → IDLE.
  - IDLE: in_ready=1. On in_valid, latch the residues and err, go to CALC_A2.
  - CALC_A2: register a2.
  - CALC_A3: register a3.
  - SUM: register out_data/out_err; set out_valid.
  - HOLD: out_valid=1. On out_ready, clear out_valid and go to IDLE.
- Illegal or unused state encodings return to IDLE.

## Timing
- Reset (asynchronous, with rst_n low):
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - out_err = 0
  - all digit registers = 0
- Accept edge E0 (IDLE, in_valid=1). out_valid is high after edge E3, which is a latency of 3 edges.
- in_ready is low from E0 until the edge that completes the output handshake. Input is ignored while in_ready=0.
- Minimum initiation interval is 5 cycles: accept, 3 calc cycles, 1 HOLD cycle with out_ready=1.
- In HOLD, out_data/out_err are stable for as long as out_ready=0, with no timeout.
- out_valid falls on the edge where out_valid & out_ready. in_ready rises on that same edge. A new triple is accepted no earlier than the following edge.
- Reset mid-operation abandons the transaction immediately. The next post-reset acceptance behaves normally.

## Structure
- Shared package `rns_pkg`:
  - constants M3=3, M5=5, M7=7, INV3_M5=2, INV5_M7=3, M35=15
  - RES_W=3, BIN_W=7
  - FSM state encoding
- Sub-module `mod_sub_reduce`: a 3-bit (a − b) mod m unit, with m as input. It is instantiated for the a2 and a3 paths.
- The FSM, range check and final sum stay in the top module.

## Test plan
- Reset with rst_n=0 for 2 cycles → in_ready=1, out_valid=0, out_data=0, out_err=0.
- Triple (1,2,3) accepted at E0 → out_valid=1 after E3, out_data=52, out_err=0. Triple (2,4,6) → 104. Triple (0,0,0) → 0.
- Exhaustive sweep of X=0..104, with residues generated by the bench → out_data=X every time, out_err=0.
- out_ready held low for 6 cycles after out_valid, with in_valid=1 and a new triple presented → out_data stable, in_ready=0, new triple not taken. out_ready=1 → handshake completes, next triple accepted one edge later.
- Triple (0,5,0) → out_err=1, out_data=0. Triple (3,0,7) → out_err=1, out_data=0.
- rst_n pulsed low while in CALC_A3 → outputs return to reset values asynchronously. Triple (2,3,1) accepted afterwards → out_data=8.
